// File: rtl/speech_phoneme_sequencer.sv
// speech_phoneme_sequencer
// Buffers phoneme pairs written by the 68k bus in a circular FIFO and plays
// them back-to-back through the phoneme speech engine. The bus is held off
// with DTACK only while the FIFO lacks room for the nonzero halves of a word.
// Optional feature macro: SPEECH_BUSY_TIMEOUT_EN adds a start-to-busy watchdog
// that drops a phoneme the engine never accepts and sets sticky speech_error.
module speech_phoneme_sequencer #(
   parameter int unsigned PH_WIDTH       = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        VoiceControl_H,
   input  logic [2*PH_WIDTH-1:0]       data,
   output logic                        VoiceDtack_L,
   input  logic                        voice_flush,
   input  logic                        phoneme_speech_busy,
   output logic [PH_WIDTH-1:0]         phoneme_sel,
   output logic                        start_phoneme_output,
   output logic                        phoneme_speech_finish,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        fifo_full,
   output logic                        speech_error
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   // Elaboration-time sanity check of the configuration
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
   begin : g_bad_config
      $error("speech_phoneme_sequencer: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK} bus_state_e;
   typedef enum logic [1:0] {S_IDLE, S_START, S_WORK, S_DONE} sp_state_e;

   bus_state_e bus_state_q, bus_state_d;
   sp_state_e  sp_state_q, sp_state_d;

   logic [PH_WIDTH-1:0] lo_q, hi_q;
   logic                latch;
   logic                lo_nz, hi_nz;
   logic [1:0]          need;
   logic [CW-1:0]       free;
   logic                push_ok, push_lo, push_hi;
   logic [1:0]          push_n;

   logic [PH_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next, hi_ptr;
   logic [CW-1:0]       count_q, count_d;
   logic                pop;

   logic [PH_WIDTH-1:0] sel_q, sel_d;
   logic                sel_load;
   logic [PH_WIDTH-1:0] head_now, head_after_pop, first_push;

   // ---------------------------------------------------------------------------
   // Bus side: word decode and FIFO push
   // ---------------------------------------------------------------------------
   assign lo_nz  = |lo_q;
   assign hi_nz  = |hi_q;
   assign need   = {1'b0, lo_nz} + {1'b0, hi_nz};
   // Free space ignores a same-cycle pop on purpose
   assign free   = CW'(FIFO_DEPTH) - count_q;
   assign push_ok = (bus_state_q == B_WAIT) && (need != 2'd0) && (free >= CW'(need)) &&
                    !voice_flush;
   assign push_lo = push_ok && lo_nz;
   assign push_hi = push_ok && hi_nz;
   assign push_n  = push_ok ? need : 2'd0;

   // Bus FSM next state and DTACK decode
   always_comb begin
      bus_state_d  = bus_state_q;
      latch        = 1'b0;
      VoiceDtack_L = 1'b1;
      unique case (bus_state_q)
         B_IDLE: begin
            if (VoiceControl_H) begin
               latch       = 1'b1;
               bus_state_d = B_WAIT;
            end
         end
         B_WAIT: begin
            // An all-zero word carries nothing to queue and is simply acknowledged
            if (need == 2'd0 || push_ok) bus_state_d = B_ACK;
         end
         B_ACK: begin
            if (VoiceControl_H) VoiceDtack_L = 1'b0;
            else                bus_state_d  = B_IDLE;
         end
         default: bus_state_d = B_IDLE;
      endcase
   end

   // Bus FSM state and latched write data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_state_q <= B_IDLE;
         lo_q        <= '0;
         hi_q        <= '0;
      end else begin
         bus_state_q <= bus_state_d;
         if (latch) begin
            lo_q <= data[PH_WIDTH-1:0];
            hi_q <= data[2*PH_WIDTH-1:PH_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------------
   assign pop     = (sp_state_q == S_DONE);
   assign rd_next = rd_ptr_q + PW'(1);
   assign hi_ptr  = push_lo ? wr_ptr_q + PW'(1) : wr_ptr_q;

   // Storage writes: low half first, high half right behind it
   always_ff @(posedge clk) begin
      if (push_lo) mem_q[wr_ptr_q] <= lo_q;
      if (push_hi) mem_q[hi_ptr]   <= hi_q;
   end

   // Pointer and occupancy update, flush overriding normal push/pop
   always_comb begin
      count_d  = count_q + CW'(push_n) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (voice_flush) begin
         unique case (sp_state_q)
            // The engine owns the head phoneme; keep it and drop the rest
            S_START, S_WORK: begin
               count_d  = CW'(1);
               wr_ptr_d = rd_next;
            end
            S_DONE: begin
               count_d  = '0;
               rd_ptr_d = rd_next;
               wr_ptr_d = rd_next;
            end
            default: begin
               count_d  = '0;
               wr_ptr_d = rd_ptr_q;
            end
         endcase
      end
   end

   // FIFO pointer and count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign fifo_count = count_q;
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

   // ---------------------------------------------------------------------------
   // Speech side
   // ---------------------------------------------------------------------------
   assign head_now   = mem_q[rd_ptr_q];
   assign first_push = lo_nz ? lo_q : hi_q;
   // With one entry left the next head is being written this very cycle
   assign head_after_pop = (count_q == CW'(1)) ? first_push : mem_q[rd_next];

`ifdef SPEECH_BUSY_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] tmo_cnt_q;
   logic          tmo_hit;
   logic          err_set;
   logic          err_q;

   assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog counter runs only while waiting for the engine to go busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        tmo_cnt_q <= '0;
      else if (sp_state_q != S_START) tmo_cnt_q <= '0;
      else                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
   end

   // Sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign speech_error = err_q;
`else
   assign speech_error = 1'b0;
`endif

   // Speech FSM next state and engine handshake outputs
   always_comb begin
      sp_state_d            = sp_state_q;
      sel_load              = 1'b0;
      sel_d                 = head_now;
      start_phoneme_output  = 1'b0;
      phoneme_speech_finish = 1'b0;
`ifdef SPEECH_BUSY_TIMEOUT_EN
      err_set               = 1'b0;
`endif
      unique case (sp_state_q)
         S_IDLE: begin
            if (count_q != '0 && !voice_flush) begin
               sp_state_d = S_START;
               sel_load   = 1'b1;
               sel_d      = head_now;
            end
         end
         S_START: begin
            start_phoneme_output = 1'b1;
            if (phoneme_speech_busy) begin
               sp_state_d = S_WORK;
            end
`ifdef SPEECH_BUSY_TIMEOUT_EN
            else if (tmo_hit) begin
               err_set    = 1'b1;
               sp_state_d = S_DONE;
            end
`endif
         end
         S_WORK: begin
            if (!phoneme_speech_busy) sp_state_d = S_DONE;
         end
         S_DONE: begin
            if (count_d == '0) begin
               phoneme_speech_finish = 1'b1;
               sp_state_d            = S_IDLE;
            end else begin
               sp_state_d = S_START;
               sel_load   = 1'b1;
               sel_d      = head_after_pop;
            end
         end
         default: sp_state_d = S_IDLE;
      endcase
   end

   // Speech FSM state and registered phoneme code
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_state_q <= S_IDLE;
         sel_q      <= '0;
      end else begin
         sp_state_q <= sp_state_d;
         if (sel_load) sel_q <= sel_d;
      end
   end

   assign phoneme_sel = sel_q;

endmodule

// File: tb/tb_speech_phoneme_sequencer.sv
// Self-checking bench for speech_phoneme_sequencer: directed scenarios with
// random phoneme data and random engine timing, checked against a queue model
// of the phonemes the engine should receive.
module tb_speech_phoneme_sequencer;

   localparam int unsigned PH_WIDTH = 8;
   localparam int unsigned DEPTH    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        VoiceControl_H;
   logic [15:0] data;
   logic        VoiceDtack_L;
   logic        voice_flush;
   logic        busy;
   logic [7:0]  phoneme_sel;
   logic        start_phoneme_output;
   logic        phoneme_speech_finish;
   logic [4:0]  fifo_count;
   logic        fifo_full;
   logic        speech_error;

   speech_phoneme_sequencer #(
      .PH_WIDTH(PH_WIDTH),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .VoiceControl_H(VoiceControl_H),
      .data(data),
      .VoiceDtack_L(VoiceDtack_L),
      .voice_flush(voice_flush),
      .phoneme_speech_busy(busy),
      .phoneme_sel(phoneme_sel),
      .start_phoneme_output(start_phoneme_output),
      .phoneme_speech_finish(phoneme_speech_finish),
      .fifo_count(fifo_count),
      .fifo_full(fifo_full),
      .speech_error(speech_error)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   bit eng_en   = 1'b0;
   bit eng_hold = 1'b0;
   int ecnt     = 0;
   int edly     = 0;
   int fin_cnt  = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   logic start_prev = 1'b0;

   // Engine model: accepts a start after a random delay, stays busy a random time
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         busy = 1'b0;
         ecnt = 0;
      end else if (busy) begin
         if (ecnt != 0)      ecnt--;
         else if (!eng_hold) busy = 1'b0;
      end else if (start_phoneme_output === 1'b1 && eng_en) begin
         if (edly == 0) begin
            got_q.push_back(phoneme_sel);
            busy = 1'b1;
            ecnt = $urandom_range(3, 0);
            edly = $urandom_range(2, 0);
         end else begin
            edly--;
         end
      end
   end

   // Event monitor: finish pulses and start requests
   always @(negedge clk) begin
      if (phoneme_speech_finish === 1'b1) fin_cnt++;
      if (start_phoneme_output === 1'b1) begin
         start_cyc++;
         if (!start_prev) start_cnt++;
      end
      start_prev = start_phoneme_output;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_write(input logic [15:0] w);
      @(posedge clk);
      #1;
      data           = w;
      VoiceControl_H = 1'b1;
   endtask

   task automatic wait_ack(input int limit, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (VoiceDtack_L !== 1'b0 && lat < limit);
      chk("dtack_low_within_bound", VoiceDtack_L, 1'b0);
   endtask

   task automatic end_write;
      @(posedge clk);
      #1;
      VoiceControl_H = 1'b0;
      data           = 16'($urandom);
      @(negedge clk);
      chk("dtack_release", VoiceDtack_L, 1'b1);
   endtask

   // Reference: each nonzero half becomes one phoneme, low half spoken first
   task automatic model_write(input logic [15:0] w);
      if (w[7:0] != 8'h00)  exp_q.push_back(w[7:0]);
      if (w[15:8] != 8'h00) exp_q.push_back(w[15:8]);
   endtask

   task automatic write_word(input logic [15:0] w, input int limit, output int lat);
      begin_write(w);
      wait_ack(limit, lat);
      model_write(w);
      end_write();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fifo_count == 5'd0 && start_phoneme_output == 1'b0 && busy == 1'b0)
                 && n < 3000);
      chk(tag, fifo_count, 5'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [15:0] rand_word(input bit allow_zero);
      logic [7:0] lo, hi;
      lo = 8'($urandom_range(255, 1));
      hi = 8'($urandom_range(255, 1));
      if (allow_zero && $urandom_range(3, 0) == 0) lo = 8'h00;
      if (allow_zero && $urandom_range(3, 0) == 0) hi = 8'h00;
      return {hi, lo};
   endfunction

   initial begin
      int lat, n, f0, s0;
      logic [7:0] keep;

      rst = 1'b1;
      VoiceControl_H = 1'b0;
      data = 16'h0000;
      voice_flush = 1'b0;
      busy = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_dtack", VoiceDtack_L, 1'b1);
      chk("rst_start", start_phoneme_output, 1'b0);
      chk("rst_sel", phoneme_sel, 8'h00);
      chk("rst_finish", phoneme_speech_finish, 1'b0);
      chk("rst_count", fifo_count, 5'd0);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_error", speech_error, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Two-phoneme word into an empty FIFO
      eng_en = 1'b1;
      f0 = fin_cnt;
      begin_write(16'h1A2B);
      wait_ack(20, lat);
      chk("a_latency", lat, 2);
      chk("a_count", fifo_count, 5'd2);
      model_write(16'h1A2B);
      end_write();
      drain("a_drain");
      check_stream("a_order");
      chk("a_finish_pulses", fin_cnt - f0, 1);

      // Single-phoneme word, then an all-zero word
      begin_write(16'h0033);
      wait_ack(20, lat);
      chk("b_count", fifo_count, 5'd1);
      model_write(16'h0033);
      end_write();
      drain("b_drain");
      check_stream("b_order");
      s0 = start_cnt;
      f0 = fin_cnt;
      begin_write(16'h0000);
      wait_ack(20, lat);
      chk("b_zero_latency", lat, 2);
      chk("b_zero_count", fifo_count, 5'd0);
      end_write();
      repeat (10) @(negedge clk);
      chk("b_zero_no_start", start_cnt - s0, 0);
      chk("b_zero_no_finish", fin_cnt - f0, 0);

      // Fill to DEPTH-1 with the engine stalled, then a word needing two slots
      eng_en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         write_word(rand_word(1'b0), 20, lat);
         chk("c_fill_latency", lat, 2);
      end
      write_word({8'h00, 8'($urandom_range(255, 1))}, 20, lat);
      chk("c_fill_count", fifo_count, 5'(DEPTH - 1));
      begin_write(16'h0102);
      repeat (10) begin
         @(negedge clk);
         chk("c_dtack_held", VoiceDtack_L, 1'b1);
      end
      eng_en = 1'b1;
      wait_ack(200, lat);
      chk("c_count_full", fifo_count, 5'(DEPTH));
      chk("c_full_flag", fifo_full, 1'b1);
      model_write(16'h0102);
      end_write();
      drain("c_drain");
      check_stream("c_wrap_order");

      // Flush while the engine is busy with five entries queued
      eng_en = 1'b0;
      write_word(16'h1112, 20, lat);
      write_word(16'h1314, 20, lat);
      write_word(16'h0015, 20, lat);
      chk("d_count", fifo_count, 5'd5);
      f0 = fin_cnt;
      eng_hold = 1'b1;
      eng_en = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b1 && n < 20);
      chk("d_busy_seen", busy, 1'b1);
      @(posedge clk);
      #1 voice_flush = 1'b1;
      @(posedge clk);
      #1 voice_flush = 1'b0;
      @(negedge clk);
      chk("d_count_after_flush", fifo_count, 5'd1);
      keep = exp_q[0];
      exp_q.delete();
      exp_q.push_back(keep);
      eng_hold = 1'b0;
      drain("d_drain");
      s0 = start_cnt;
      repeat (20) @(negedge clk);
      chk("d_no_restart", start_cnt - s0, 0);
      chk("d_finish_pulses", fin_cnt - f0, 1);
      check_stream("d_order");

      // Asynchronous reset in the middle of a phoneme with DTACK asserted
      eng_en = 1'b0;
      write_word(16'h2122, 20, lat);
      eng_hold = 1'b1;
      eng_en = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b1 && n < 20);
      begin_write(16'h0023);
      wait_ack(20, lat);
      chk("e_count", fifo_count, 5'd3);
      #2 rst = 1'b0;
      #1;
      chk("e_rst_dtack", VoiceDtack_L, 1'b1);
      chk("e_rst_start", start_phoneme_output, 1'b0);
      chk("e_rst_sel", phoneme_sel, 8'h00);
      chk("e_rst_finish", phoneme_speech_finish, 1'b0);
      chk("e_rst_count", fifo_count, 5'd0);
      chk("e_rst_full", fifo_full, 1'b0);
      chk("e_rst_error", speech_error, 1'b0);
      VoiceControl_H = 1'b0;
      eng_hold = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      got_q.delete();
      exp_q.delete();
      s0 = start_cnt;
      repeat (20) @(negedge clk);
      chk("e_no_start_after_release", start_cnt - s0, 0);
      chk("e_count_after_release", fifo_count, 5'd0);

      // Random burst with the engine running
      for (int k = 0; k < 12; k++) begin
         write_word(rand_word(1'b1), 500, lat);
         repeat ($urandom_range(3, 0)) @(posedge clk);
      end
      drain("r_drain");
      check_stream("r_order");

`ifdef SPEECH_BUSY_TIMEOUT_EN
      // Head phoneme never accepted: dropped after the watchdog expires
      eng_en = 1'b0;
      s0 = start_cyc;
      write_word(16'h0506, 20, lat);
      n = 0;
      while (speech_error !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      eng_en = 1'b1;
      chk("t_error_set", speech_error, 1'b1);
      chk("t_start_cycles", start_cyc - s0, 8);
      void'(exp_q.pop_front());
      drain("t_drain");
      check_stream("t_order");
      chk("t_error_sticky", speech_error, 1'b1);
`else
      chk("error_tied_low", speech_error, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
